jtag_bitbang_sequencer: RTL

- Converts word-level JTAG shift commands into the remote-bitbang byte protocol consumed by the UART-side bitbang engine, and collects TDO replies.
- Sits between a host-side debug master and the bitbang engine's byte streams.
- Sequences one bit per byte, inserts read requests when capture is enabled, and parks TCK low at the end.
- Returns one response word per command.

---
 rtl/jtag_bitbang_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/jtag_bitbang_sequencer.sv
// Purpose: word-level JTAG shifts to remote-bitbang ASCII bytes, TDO collected into one response word (JTAG_SEQ_TIMEOUT_EN adds a TDO reply timeout).
// Latency: first byte the cycle after command accept; len_eff==0 responds the cycle after accept.
// Backpressure: bb_data held while !bb_ready, one outstanding read, response held until rsp_ready.
module jtag_bitbang_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_tms,
    input  logic [MAX_LEN-1:0] cmd_tdi,
    input  logic               cmd_capture,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_tdo,
    output logic               rsp_err,
    output logic               bb_valid,
    output logic [7:0]         bb_data,
    input  logic               bb_ready,
    input  logic               bb_rsp_valid,
    input  logic [7:0]         bb_rsp_data,
    output logic               bb_rsp_ready,
    output logic               busy
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_WAIT_TDO = 3'd2;
    localparam logic [2:0] ST_PARK     = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    logic [2:0]         state;
    logic [LEN_W-1:0]   bit_idx;
    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] tms_q;
    logic [MAX_LEN-1:0] tdi_q;
    logic [MAX_LEN-1:0] tdo_q;
    logic               cap_q;
    logic               err_q;
    logic [LEN_W-1:0]   cmd_len_eff;
    logic [IDX_W-1:0]   sel;
    logic [1:0]         k;
    logic               last_bit;
    logic               tmo_hit;

    assign cmd_len_eff = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    // The park byte reuses the final bit's TMS/TDI so only TCK changes
    assign sel      = (state == ST_PARK) ? IDX_W'(len_eff - LEN_W'(1)) : IDX_W'(bit_idx);
    assign k        = {tms_q[sel], tdi_q[sel]};
    assign last_bit = (bit_idx == len_eff - LEN_W'(1));

    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign bb_valid     = (state == ST_SEND) || (state == ST_PARK);
    assign bb_rsp_ready = (state == ST_IDLE) || (state == ST_WAIT_TDO);
    assign rsp_valid    = (state == ST_RESP);
    assign rsp_tdo      = tdo_q;
    assign rsp_err      = err_q;

    always_comb begin
        bb_data = 8'h00;
        if (state == ST_SEND) begin
            if (cap_q) begin
                case (k)
                    2'd0:    bb_data = "$";
                    2'd1:    bb_data = "%";
                    2'd2:    bb_data = "^";
                    default: bb_data = "&";
                endcase
            end else begin
                case (k)
                    2'd0:    bb_data = ")";
                    2'd1:    bb_data = "!";
                    2'd2:    bb_data = "@";
                    default: bb_data = "#";
                endcase
            end
        end else if (state == ST_PARK) begin
            bb_data = 8'h30 | {6'd0, k};
        end
    end

`ifdef JTAG_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero outside WAIT_TDO, so every entry starts a fresh count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != ST_WAIT_TDO) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            len_eff <= '0;
            tms_q   <= '0;
            tdi_q   <= '0;
            tdo_q   <= '0;
            cap_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        tms_q   <= cmd_tms;
                        tdi_q   <= cmd_tdi;
                        cap_q   <= cmd_capture;
                        len_eff <= cmd_len_eff;
                        state   <= (cmd_len_eff == '0) ? ST_RESP : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bb_ready) begin
                        if (cap_q) begin
                            state <= ST_WAIT_TDO;
                        end else begin
                            bit_idx <= bit_idx + LEN_W'(1);
                            if (last_bit) state <= ST_PARK;
                        end
                    end
                end
                ST_WAIT_TDO: begin
                    if (bb_rsp_valid) begin
                        if (bb_rsp_data == "1") begin
                            tdo_q[sel] <= 1'b1;
                        end else if (bb_rsp_data != "0") begin
                            err_q <= 1'b1;
                        end
                        bit_idx <= bit_idx + LEN_W'(1);
                        state   <= last_bit ? ST_PARK : ST_SEND;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= ST_PARK;
                    end
                end
                ST_PARK: begin
                    if (bb_ready) state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                        tdo_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
